// File: rtl/bitmap_mem_arbiter.sv
// bitmap_mem_arbiter: shares the bitmap memory between display fetches (priority) and a burst probe engine
module bitmap_mem_arbiter #(
  parameter int Abits        = 11,
  parameter int Dbits        = 8,
  parameter int DEPTH        = 1280,
  parameter int Lbits        = 7,
  parameter int STARVE_LIMIT = 64
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             disp_req,
  input  logic [Abits-1:0] disp_addr,
  output logic             disp_valid,
  output logic [Dbits-1:0] disp_data,
  input  logic             prb_start,
  input  logic [Abits-1:0] prb_base,
  input  logic [Lbits-1:0] prb_len,
  output logic             prb_busy,
  output logic             prb_rvalid,
  output logic [Dbits-1:0] prb_rdata,
  output logic             prb_rlast,
  output logic             prb_err,
  output logic             prb_starved,
  output logic [Abits-1:0] bm_addr,
  input  logic [Dbits-1:0] bm_dout
);
  localparam int Wbits = $clog2(STARVE_LIMIT + 1);
  localparam logic [Abits:0] DEPTH_W = (Abits+1)'(DEPTH);
  localparam logic [Wbits-1:0] LIMIT_W = Wbits'(STARVE_LIMIT);
  typedef enum logic {IDLE, BURST} state_t;
  state_t state_q, state_d;
  logic [Abits-1:0] base_q, base_d;
  logic [Lbits-1:0] len_q, len_d, off_q, off_d;
  logic [Wbits-1:0] wait_q, wait_d;
  logic disp_valid_q, disp_valid_d, prb_rvalid_q, prb_rvalid_d, prb_rlast_q, prb_rlast_d;
  logic prb_err_q, prb_err_d, prb_starved_q, prb_starved_d;
  logic [Dbits-1:0] disp_data_q, disp_data_d, prb_rdata_q, prb_rdata_d;
  logic prb_gnt, prb_last, prb_oor, start_ok;
  logic [Abits:0] prb_addr;
  always_comb begin
    prb_addr      = {1'b0, base_q} + (Abits+1)'(off_q);
    prb_gnt       = state_q == BURST && !disp_req;
    prb_last      = prb_gnt && off_q == len_q - 1'b1;
    prb_oor       = prb_addr >= DEPTH_W;
    start_ok      = state_q == IDLE && prb_start && prb_len != '0;
    bm_addr       = disp_req ? disp_addr : prb_gnt ? prb_addr[Abits-1:0] : '0;
    state_d       = start_ok ? BURST : prb_last ? IDLE : state_q;
    base_d        = start_ok ? prb_base : base_q;
    len_d         = start_ok ? prb_len : len_q;
    off_d         = start_ok ? '0 : prb_gnt ? off_q + 1'b1 : off_q;
    wait_d        = (start_ok || prb_gnt) ? '0 :
                    (state_q == BURST && disp_req && wait_q != LIMIT_W) ? wait_q + 1'b1 : wait_q;
    disp_valid_d  = disp_req;
    disp_data_d   = (disp_req && {1'b0, disp_addr} < DEPTH_W) ? bm_dout : '0;
    prb_rvalid_d  = prb_gnt;
    prb_rdata_d   = (prb_gnt && !prb_oor) ? bm_dout : '0;
    prb_rlast_d   = prb_last;
    prb_err_d     = start_ok ? 1'b0 : prb_err_q | (prb_gnt & prb_oor);
    prb_starved_d = start_ok ? 1'b0 : prb_starved_q | (wait_d == LIMIT_W);
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      base_q        <= '0;
      len_q         <= '0;
      off_q         <= '0;
      wait_q        <= '0;
      disp_valid_q  <= 1'b0;
      disp_data_q   <= '0;
      prb_rvalid_q  <= 1'b0;
      prb_rdata_q   <= '0;
      prb_rlast_q   <= 1'b0;
      prb_err_q     <= 1'b0;
      prb_starved_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      base_q        <= base_d;
      len_q         <= len_d;
      off_q         <= off_d;
      wait_q        <= wait_d;
      disp_valid_q  <= disp_valid_d;
      disp_data_q   <= disp_data_d;
      prb_rvalid_q  <= prb_rvalid_d;
      prb_rdata_q   <= prb_rdata_d;
      prb_rlast_q   <= prb_rlast_d;
      prb_err_q     <= prb_err_d;
      prb_starved_q <= prb_starved_d;
    end
  end
  assign prb_busy    = state_q == BURST;
  assign disp_valid  = disp_valid_q;
  assign disp_data   = disp_data_q;
  assign prb_rvalid  = prb_rvalid_q;
  assign prb_rdata   = prb_rdata_q;
  assign prb_rlast   = prb_rlast_q;
  assign prb_err     = prb_err_q;
  assign prb_starved = prb_starved_q;
endmodule

// File: tb/tb_bitmap_mem_arbiter.sv
// tb_bitmap_mem_arbiter: scoreboard bench for bitmap_mem_arbiter
module tb_bitmap_mem_arbiter;
  localparam int DEPTH = 1280;
  logic clk = 1'b0;
  logic reset_n;
  logic disp_req;
  logic [10:0] disp_addr;
  logic disp_valid;
  logic [7:0] disp_data;
  logic prb_start;
  logic [10:0] prb_base;
  logic [6:0] prb_len;
  logic prb_busy, prb_rvalid, prb_rlast, prb_err, prb_starved;
  logic [7:0] prb_rdata;
  logic [10:0] bm_addr;
  logic [7:0] bm_dout;
  logic [7:0] mem [0:DEPTH-1];
  logic [7:0] disp_q [$];
  logic [8:0] prb_q [$];
  logic [8:0] pe;
  int pass_cnt = 0;
  int total = 0;

  bitmap_mem_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .disp_req(disp_req), .disp_addr(disp_addr), .disp_valid(disp_valid), .disp_data(disp_data),
    .prb_start(prb_start), .prb_base(prb_base), .prb_len(prb_len), .prb_busy(prb_busy),
    .prb_rvalid(prb_rvalid), .prb_rdata(prb_rdata), .prb_rlast(prb_rlast),
    .prb_err(prb_err), .prb_starved(prb_starved),
    .bm_addr(bm_addr), .bm_dout(bm_dout)
  );

  always #5 clk = ~clk;
  // Out-of-range reads return junk so the DUT's zero forcing is observable
  assign bm_dout = (bm_addr < 11'(DEPTH)) ? mem[bm_addr] : 8'hEE;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      if (disp_valid) begin
        if (disp_q.size() == 0) begin
          total++;
          $display("FAIL disp_unexpected: got beat %0h expected none", disp_data);
        end else check("disp_data", disp_data, disp_q.pop_front());
      end
      if (prb_rvalid) begin
        if (prb_q.size() == 0) begin
          total++;
          $display("FAIL prb_unexpected: got beat %0h expected none", prb_rdata);
        end else begin
          pe = prb_q.pop_front();
          check("prb_rdata", prb_rdata, pe[7:0]);
          check("prb_rlast", prb_rlast, pe[8]);
          check("prb_busy_vs_rlast", prb_busy, !prb_rlast);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic disp(input int a);
    disp_req = 1'b1;
    disp_addr = 11'(a);
    disp_q.push_back(a < DEPTH ? mem[a] : 8'h00);
  endtask

  task automatic start(input int base, input int len, input bit push);
    prb_start = 1'b1;
    prb_base = 11'(base);
    prb_len = 7'(len);
    if (push)
      for (int i = 0; i < len; i++)
        prb_q.push_back({i == len - 1, (base + i < DEPTH) ? mem[base + i] : 8'h00});
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((prb_busy || prb_q.size() != 0 || disp_q.size() != 0) && n < 300) begin
      tick();
      n++;
    end
    check(name, n < 300, 1);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_disp_valid"}, disp_valid, 0);
    check({tag, "_disp_data"}, disp_data, 0);
    check({tag, "_prb_busy"}, prb_busy, 0);
    check({tag, "_prb_rvalid"}, prb_rvalid, 0);
    check({tag, "_prb_rdata"}, prb_rdata, 0);
    check({tag, "_prb_rlast"}, prb_rlast, 0);
    check({tag, "_prb_err"}, prb_err, 0);
    check({tag, "_prb_starved"}, prb_starved, 0);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = 8'(i * 37 + 5);
    mem[0] = 8'h11;
    mem[1] = 8'h22;
    mem[2] = 8'h33;
    reset_n = 1'b0;
    disp_req = 1'b0;
    disp_addr = '0;
    prb_start = 1'b0;
    prb_base = '0;
    prb_len = '0;
    #12;
    check_zero("reset");
    reset_n = 1'b1;
    tick();
    // display only, including an out-of-range fetch
    for (int a = 0; a < 3; a++) begin
      disp(a);
      tick();
    end
    disp(1500);
    tick();
    disp_req = 1'b0;
    tick();
    check("disp_only_busy", prb_busy, 0);
    drain("disp_only_drain");
    // burst without contention
    start(100, 4, 1);
    tick();
    prb_start = 1'b0;
    check("burst100_busy", prb_busy, 1);
    drain("burst100_drain");
    check("burst100_err", prb_err, 0);
    // interleave with display every other cycle
    start(0, 3, 1);
    disp(50);
    tick();
    prb_start = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (k % 2 == 1) disp(60 + k);
      else disp_req = 1'b0;
      tick();
    end
    disp_req = 1'b0;
    drain("interleave_drain");
    // starvation: start cycle plus 69 blocked burst cycles
    start(200, 2, 1);
    for (int i = 0; i < 70; i++) begin
      disp(i);
      tick();
      if (i == 0) prb_start = 1'b0;
      if (i == 63) check("starved_early", prb_starved, 0);
      if (i == 64) check("starved_set", prb_starved, 1);
      if (i == 69) check("starved_busy", prb_busy, 1);
    end
    disp_req = 1'b0;
    drain("starve_drain");
    check("starved_sticky", prb_starved, 1);
    check("starve_err", prb_err, 0);
    // out-of-range burst
    start(1278, 4, 1);
    tick();
    prb_start = 1'b0;
    drain("oor_drain");
    check("oor_err", prb_err, 1);
    check("oor_starved_cleared", prb_starved, 0);
    // ignored starts
    start(300, 0, 0);
    tick();
    prb_start = 1'b0;
    check("len0_busy", prb_busy, 0);
    tick();
    check("len0_busy2", prb_busy, 0);
    start(300, 5, 1);
    tick();
    check("start_err_cleared", prb_err, 0);
    start(400, 7, 0);
    tick();
    prb_start = 1'b0;
    drain("ignored_start_drain");
    // asynchronous reset mid-burst
    start(500, 20, 1);
    tick();
    prb_start = 1'b0;
    repeat (5) tick();
    #2;
    reset_n = 1'b0;
    #1;
    check_zero("midreset");
    prb_q.delete();
    repeat (2) tick();
    #2;
    reset_n = 1'b1;
    repeat (5) tick();
    check("post_reset_busy", prb_busy, 0);
    start(600, 2, 1);
    tick();
    prb_start = 1'b0;
    drain("post_reset_drain");
    check("post_reset_err", prb_err, 0);
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule

// File: doc/bitmap_mem_arbiter.md
Name: bitmap_mem_arbiter

Overview:
- Shares the single bitmap memory between two requesters.
  - Display pixel-fetch path: hard priority, fixed 1-cycle latency.
  - Burst probe engine: collision/sprite checks that stream consecutive bitmap bytes.
- Drives the memory address, registers the memory's combinational data output, and steers it to the granted requester.
- Sits between the VGA pixel pipeline, the collision checker and the bitmap memory.

Parameters:
- Abits, 11, bitmap address width.
- Dbits, 8, bitmap data width.
- DEPTH, 1280, number of valid bitmap entries (addresses 0..DEPTH-1).
- Lbits, 7, burst length field width (max burst 2^Lbits-1 = 127).
- STARVE_LIMIT, 64, consecutive blocked cycles before the probe starvation flag sets.

Ports:
- clk  in  1  system clock, all state on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- disp_req  in  1  display fetch request this cycle.
- disp_addr  in  Abits  display fetch address.
- disp_valid  out  1  display data valid; 1 cycle after disp_req.
- disp_data  out  Dbits  display fetch data.
- prb_start  in  1  start-burst pulse.
- prb_base  in  Abits  burst start address.
- prb_len  in  Lbits  burst length in bytes.
- prb_busy  out  1  burst in progress; start is ignored while high.
- prb_rvalid  out  1  burst data beat valid.
- prb_rdata  out  Dbits  burst data beat.
- prb_rlast  out  1  marks the final beat; coincides with prb_rvalid.
- prb_err  out  1  sticky: burst touched an out-of-range address.
- prb_starved  out  1  sticky: probe was blocked STARVE_LIMIT consecutive cycles.
- bm_addr  out  Abits  address to bitmap memory (combinational from the grant).
- bm_dout  in  Dbits  bitmap memory data (combinational read).

Behaviour:
- Reset (reset_n=0, asynchronous):
  - FSM goes to IDLE.
  - All outputs are 0: disp_valid, disp_data, prb_busy, prb_rvalid, prb_rdata, prb_rlast, prb_err, prb_starved.
  - Internal offset and wait counters are 0.
  - A burst in flight is abandoned; no beats are emitted after reset release until a new prb_start.
- Grant: disp_req=1 always wins. bm_addr=disp_addr.
  - Else, in BURST, bm_addr=prb_base_r+offset.
  - Else bm_addr=0.
- Latency: the grant in cycle N captures bm_dout at the edge ending N. The matching valid is high for exactly one cycle in N+1.
  - Back-to-back grants give valid every cycle.
- Out-of-range (address >= DEPTH): the captured data is forced to 0.
  - Display side: no flag.
  - Probe side: sets prb_err.
  - Offset never wraps past 2^Abits. The address is computed at Abits+1 width and compared against DEPTH.
- FSM states:
  - IDLE: prb_start=1 with prb_len!=0 latches base and len, clears offset, clears prb_err and prb_starved, and sets prb_busy=1 next cycle. Next state is BURST.
    - prb_start with prb_len=0 is ignored; the FSM stays in IDLE.
  - BURST: in each cycle with disp_req=0, read base+offset and increment offset.
    - The read where offset=len-1 goes to IDLE. prb_busy=0 from the next cycle, the same cycle as prb_rvalid with prb_rlast=1.
    - Cycles with disp_req=1 stall the burst and offset is held.
    - prb_start while prb_busy=1 is ignored; the latched values are unchanged.
- Starvation:
  - The wait counter increments in BURST on each cycle with disp_req=1 and saturates at STARVE_LIMIT.
  - It clears on any probe grant.
  - Reaching STARVE_LIMIT sets prb_starved. The flag is sticky until the next accepted start or reset. Display priority is unchanged.
- Simultaneous prb_start and disp_req in IDLE: the start is accepted. The first probe read occurs no earlier than the following cycle.
- Beats are delivered strictly in address order with no gaps other than display stalls. Exactly len beats are delivered per burst.

Test Plan:
- Display only: disp_req=1 for addr 0,1,2 on consecutive cycles with mem[0..2]=0x11,0x22,0x33 -> disp_valid=1 on the next 3 cycles, disp_data=0x11,0x22,0x33; probe outputs stay 0.
- Burst with no contention: prb_start with base=100, len=4 -> prb_rvalid on 4 consecutive cycles, rdata=mem[100..103], rlast only on the 4th beat, prb_busy falls in the same cycle as rlast.
- Interleave: burst base=0, len=3 with disp_req high every other cycle -> display served every time it requests; probe beats mem[0],mem[1],mem[2] in order, one after each free cycle; total 3 beats.
- Starvation and out-of-range:
  - disp_req held high for 70 cycles during a burst -> prb_starved=1 after 64 blocked cycles; the burst completes after disp_req drops.
  - Burst base=1278, len=4 -> beats mem[1278], mem[1279], 0, 0 and prb_err=1.
- Reset mid-burst: assert reset_n=0 asynchronously mid-cycle during a len=20 burst -> all outputs 0 immediately; after release no beats appear and prb_busy=0; a new start with len=2 completes normally.
- Ignored starts: prb_start with len=0 -> busy stays 0, no beats; a second prb_start during an active burst -> the original base/len complete unchanged.
